// File: rtl/writeback_arbiter_if.sv
// Signal bundle between the write-back arbiter, the MEM/WB stage, the long-latency
// unit, the register-file write port and the hazard unit.
interface writeback_arbiter_if;
    logic        wb_valid;
    logic        wb_regwrite;
    logic        wb_memtoreg;
    logic [4:0]  wb_dest;
    logic [31:0] wb_aluresult;
    logic [31:0] wb_memdata;
    logic        wb_stall;

    // lu_valid/lu_ready: a result moves when both are 1 at a rising edge; lu_ready
    // does not depend on lu_valid, and the offer stays put until it moves.
    logic        lu_valid;
    logic [4:0]  lu_dest;
    logic [31:0] lu_data;
    logic        lu_ready;

    logic [4:0]  writeadr;
    logic [31:0] WriteData;
    logic        RegWrite;

    logic [4:0]  q_adr1;
    logic [4:0]  q_adr2;
    logic        q_pending1;
    logic        q_pending2;

    modport master (
        input  wb_valid, wb_regwrite, wb_memtoreg, wb_dest, wb_aluresult, wb_memdata,
        input  lu_valid, lu_dest, lu_data,
        input  q_adr1, q_adr2,
        output wb_stall, lu_ready,
        output writeadr, WriteData, RegWrite,
        output q_pending1, q_pending2
    );

    modport slave (
        output wb_valid, wb_regwrite, wb_memtoreg, wb_dest, wb_aluresult, wb_memdata,
        output lu_valid, lu_dest, lu_data,
        output q_adr1, q_adr2,
        input  wb_stall, lu_ready,
        input  writeadr, WriteData, RegWrite,
        input  q_pending1, q_pending2
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges in-order MEM/WB results and out-of-band long-latency results onto the
// single register-file write port, queueing long-latency results in a small FIFO.
module writeback_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    writeback_arbiter_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [3:0] AGE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {SRC_NONE, SRC_PIPE, SRC_FIFO, SRC_BYPASS} src_e;

    logic [4:0]    dest_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    age_q, age_d;
    logic [4:0]    writeadr_q, writeadr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          regwrite_q, regwrite_d;

    logic          fifo_full, fifo_nonempty, lu_xfer, pipe_req, starve;
    logic          pop, push;
    src_e          src;
    logic [PW-1:0] off;
    logic          pend1, pend2;

    assign fifo_full     = (count_q == CW'(DEPTH));
    assign fifo_nonempty = (count_q != '0);
    assign lu_xfer       = bus.lu_valid & ~fifo_full;
    assign pipe_req      = bus.wb_valid & bus.wb_regwrite & (bus.wb_dest != 5'd0);
    assign starve        = fifo_nonempty & (age_q == AGE_MAX);

    always_comb begin
        src = SRC_NONE;
        if (starve)
            src = SRC_FIFO;
        else if (pipe_req)
            src = SRC_PIPE;
        else if (fifo_nonempty)
            src = SRC_FIFO;
        else if (lu_xfer && bus.lu_dest != 5'd0)
            src = SRC_BYPASS;

        pop  = (src == SRC_FIFO);
        // Results for $0 are accepted but never stored or written.
        push = lu_xfer && (bus.lu_dest != 5'd0) && (src != SRC_BYPASS);

        regwrite_d = (src != SRC_NONE);
        writeadr_d = writeadr_q;
        wdata_d    = wdata_q;
        case (src)
            SRC_PIPE: begin
                writeadr_d = bus.wb_dest;
                wdata_d    = bus.wb_memtoreg ? bus.wb_memdata : bus.wb_aluresult;
            end
            SRC_FIFO: begin
                writeadr_d = dest_q[head_q];
                wdata_d    = data_q[head_q];
            end
            SRC_BYPASS: begin
                writeadr_d = bus.lu_dest;
                wdata_d    = bus.lu_data;
            end
            default: ;
        endcase

        head_d  = pop  ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);

        if (pop || !fifo_nonempty)
            age_d = 4'd0;
        else if (age_q != AGE_MAX)
            age_d = age_q + 4'd1;
        else
            age_d = age_q;
    end

    // An entry is live when its distance from head is below the occupancy count.
    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head_q;
            if ({1'b0, off} < count_q) begin
                if (dest_q[i] == bus.q_adr1) pend1 = 1'b1;
                if (dest_q[i] == bus.q_adr2) pend2 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            age_q      <= 4'd0;
            regwrite_q <= 1'b0;
            writeadr_q <= 5'd0;
            wdata_q    <= 32'd0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            age_q      <= age_d;
            regwrite_q <= regwrite_d;
            writeadr_q <= writeadr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[tail_q] <= bus.lu_dest;
            data_q[tail_q] <= bus.lu_data;
        end
    end

    assign bus.wb_stall   = starve;
    assign bus.lu_ready   = ~fifo_full;
    assign bus.writeadr   = writeadr_q;
    assign bus.WriteData  = wdata_q;
    assign bus.RegWrite   = regwrite_q;
    assign bus.q_pending1 = pend1 & (bus.q_adr1 != 5'd0);
    assign bus.q_pending2 = pend2 & (bus.q_adr2 != 5'd0);
endmodule
